// File: rtl/bpi_pkg.sv
// Shared types and constants for the BPI flash bus cycle engine:
// state encoding, default bus timings and bus widths.
package bpi_pkg;

    localparam int unsigned BPI_AW = 23;
    localparam int unsigned BPI_DW = 16;
    localparam int unsigned CNT_W  = 8;

    localparam int unsigned T_SETUP_DEF = 2;
    localparam int unsigned T_WE_DEF    = 4;
    localparam int unsigned T_ACC_DEF   = 8;
    localparam int unsigned T_HOLD_DEF  = 2;
    localparam int unsigned T_REC_DEF   = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_HOLD    = 3'd3,
        ST_RECOVER = 3'd4
    } bpi_state_e;

    // A phase of N cycles loads N-1 and advances when the counter reads zero.
    function automatic logic [CNT_W-1:0] ld_val(input int unsigned cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/bpi_dly_cnt.sv
// Phase delay counter: loads a value, decrements to zero and holds there.
module bpi_dly_cnt
    import bpi_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ld_i,
    input  logic [CNT_W-1:0] ld_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (ld_i) begin
            cnt_d = ld_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/bpi_cycle_engine.sv
// Timed asynchronous BPI flash read/write cycle engine with sequencer handshake.
// Optional macro BPI_DQ_REG_EN: register BPI_DQ_I before capture (read strobe +1 cycle).
module bpi_cycle_engine
    import bpi_pkg::*;
#(
    parameter int unsigned T_SETUP = T_SETUP_DEF,
    parameter int unsigned T_WE    = T_WE_DEF,
    parameter int unsigned T_ACC   = T_ACC_DEF,
    parameter int unsigned T_HOLD  = T_HOLD_DEF,
    parameter int unsigned T_REC   = T_REC_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EXECUTE,
    input  logic              CYCLE2,
    input  logic              WR,
    input  logic [BPI_AW-1:0] ADDR,
    input  logic [BPI_DW-1:0] DATA1,
    input  logic [BPI_DW-1:0] DATA2,
    output logic              RDY,
    output logic              BUSY,
    output logic              LD_DAT,
    output logic [BPI_DW-1:0] RDATA,
    output logic [BPI_AW-1:0] BPI_A,
    input  logic [BPI_DW-1:0] BPI_DQ_I,
    output logic [BPI_DW-1:0] BPI_DQ_O,
    output logic              BPI_DQ_OE,
    output logic              BPI_CE_B,
    output logic              BPI_OE_B,
    output logic              BPI_WE_B,
    output logic              BPI_ADV_B
);

    localparam logic [CNT_W-1:0] SETUP_LD = ld_val(T_SETUP);
    localparam logic [CNT_W-1:0] WE_LD    = ld_val(T_WE);
    localparam logic [CNT_W-1:0] HOLD_LD  = ld_val(T_HOLD);
    localparam logic [CNT_W-1:0] REC_LD   = ld_val(T_REC);
`ifdef BPI_DQ_REG_EN
    localparam logic [CNT_W-1:0] ACC_LD   = ld_val(T_ACC + 1);
`else
    localparam logic [CNT_W-1:0] ACC_LD   = ld_val(T_ACC);
`endif

    bpi_state_e        state_q, state_d;
    logic              armed_q, armed_d;
    logic              wr_q, wr_d;
    logic [BPI_AW-1:0] addr_q, addr_d;
    logic [BPI_DW-1:0] wdata_q, wdata_d;
    logic [BPI_DW-1:0] rdata_q, rdata_d;
    logic              ld_dat_q, ld_dat_d;
    logic              busy_q, busy_d;
    logic              rdy_q, rdy_d;
    logic              ce_b_q, ce_b_d;
    logic              oe_b_q, oe_b_d;
    logic              we_b_q, we_b_d;
    logic              adv_b_q, adv_b_d;
    logic              dq_oe_q, dq_oe_d;

    logic              cnt_ld;
    logic [CNT_W-1:0]  cnt_val;
    logic              cnt_zero;
    logic              start;
    logic              capture;
    logic [BPI_DW-1:0] dq_src;

`ifdef BPI_DQ_REG_EN
    logic [BPI_DW-1:0] dq_in_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dq_in_q <= '0;
        end else begin
            dq_in_q <= BPI_DQ_I;
        end
    end

    assign dq_src = dq_in_q;
`else
    assign dq_src = BPI_DQ_I;
`endif

    bpi_dly_cnt u_dly_cnt (
        .clk_i    (CLK),
        .rst_i    (RST),
        .ld_i     (cnt_ld),
        .ld_val_i (cnt_val),
        .zero_o   (cnt_zero)
    );

    assign start = (state_q == ST_IDLE) && EXECUTE && armed_q;

    always_comb begin : fsm_next
        state_d = state_q;
        cnt_ld  = 1'b0;
        cnt_val = '0;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SETUP;
                    cnt_ld  = 1'b1;
                    cnt_val = SETUP_LD;
                end
            end
            ST_SETUP: begin
                if (cnt_zero) begin
                    state_d = ST_STROBE;
                    cnt_ld  = 1'b1;
                    cnt_val = wr_q ? WE_LD : ACC_LD;
                end
            end
            ST_STROBE: begin
                if (cnt_zero) begin
                    state_d = ST_HOLD;
                    cnt_ld  = 1'b1;
                    cnt_val = HOLD_LD;
                    capture = !wr_q;
                end
            end
            ST_HOLD: begin
                if (cnt_zero) begin
                    state_d = ST_RECOVER;
                    cnt_ld  = 1'b1;
                    cnt_val = REC_LD;
                end
            end
            ST_RECOVER: begin
                if (cnt_zero) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pins are registered from the next state so each phase's pin levels
    // appear exactly on the cycles the counter assigns to that phase.
    always_comb begin : out_next
        armed_d  = !EXECUTE || (armed_q && !start);
        wr_d     = start ? WR : wr_q;
        addr_d   = start ? ADDR : addr_q;
        wdata_d  = start ? (CYCLE2 ? DATA2 : DATA1) : wdata_q;
        rdata_d  = capture ? dq_src : rdata_q;
        ld_dat_d = capture;
        busy_d   = (state_d != ST_IDLE);
        rdy_d    = (state_d == ST_IDLE) && armed_d && !EXECUTE;
        ce_b_d   = !(state_d inside {ST_SETUP, ST_STROBE, ST_HOLD});
        adv_b_d  = !(state_d inside {ST_SETUP, ST_STROBE});
        we_b_d   = !((state_d == ST_STROBE) && wr_d);
        oe_b_d   = !((state_d == ST_STROBE) && !wr_d);
        dq_oe_d  = wr_d && !ce_b_d;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            armed_q  <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            ld_dat_q <= 1'b0;
            busy_q   <= 1'b0;
            rdy_q    <= 1'b0;
            ce_b_q   <= 1'b1;
            oe_b_q   <= 1'b1;
            we_b_q   <= 1'b1;
            adv_b_q  <= 1'b1;
            dq_oe_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            armed_q  <= armed_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            ld_dat_q <= ld_dat_d;
            busy_q   <= busy_d;
            rdy_q    <= rdy_d;
            ce_b_q   <= ce_b_d;
            oe_b_q   <= oe_b_d;
            we_b_q   <= we_b_d;
            adv_b_q  <= adv_b_d;
            dq_oe_q  <= dq_oe_d;
        end
    end

    assign RDY       = rdy_q;
    assign BUSY      = busy_q;
    assign LD_DAT    = ld_dat_q;
    assign RDATA     = rdata_q;
    assign BPI_A     = addr_q;
    assign BPI_DQ_O  = wdata_q;
    assign BPI_DQ_OE = dq_oe_q;
    assign BPI_CE_B  = ce_b_q;
    assign BPI_OE_B  = oe_b_q;
    assign BPI_WE_B  = we_b_q;
    assign BPI_ADV_B = adv_b_q;

endmodule

// File: doc/bpi_cycle_engine.md
# bpi_cycle_engine

Flash bus cycle engine sitting directly downstream of the BPI control sequencer. It consumes the sequencer's EXECUTE/CYCLE2 strobes, runs one timed asynchronous BPI flash bus cycle (read or write) per request, and returns RDY, BUSY and LD_DAT handshakes to the sequencer. It is the only block that drives the flash CE/OE/WE/ADV pins and the DQ tristate.

## Interface
- T_SETUP, default 2: cycles of address/CE setup before the strobe (1..255)
- T_WE, default 4: WE_B low width for write cycles, in cycles (1..255)
- T_ACC, default 8: OE_B low cycles before read data capture (1..255)
- T_HOLD, default 2: address/data hold after the strobe is released (1..255)
- T_REC, default 2: CE_B high recovery before RDY re-asserts (1..255)
- CLK  in  1  system clock
- RST  in  1  reset; asynchronous, active-high
- EXECUTE  in  1  start request from sequencer; held until BUSY seen
- CYCLE2  in  1  selects DATA2 (high) or DATA1 (low) as write data
- WR  in  1  1 = write cycle, 0 = read cycle; sampled at start
- ADDR  in  23  flash word address; sampled at start
- DATA1  in  16  first-cycle write data
- DATA2  in  16  second-cycle write data
- RDY  out  1  engine idle and armed
- BUSY  out  1  bus cycle in progress
- LD_DAT  out  1  one-cycle pulse: RDATA updated
- RDATA  out  16  last captured read word
- BPI_A  out  23  flash address
- BPI_DQ_I  in  16  flash data in
- BPI_DQ_O  out  16  flash data out
- BPI_DQ_OE  out  1  1 = drive DQ
- BPI_CE_B, BPI_OE_B, BPI_WE_B, BPI_ADV_B  out  1 each  active-low flash controls

## Operation
- States: IDLE, SETUP, STROBE, HOLD, RECOVER. Single down-counter, loaded on every state entry with (T_x − 1); state advances when counter is 0.
- Arm flag: set whenever EXECUTE is low; cleared on start. Start = IDLE & EXECUTE & armed. A held EXECUTE never starts a second cycle.
- Start: latch WR, ADDR, data (CYCLE2 ? DATA2 : DATA1); go to SETUP.
- SETUP (T_SETUP): CE_B=0, ADV_B=0, A driven; write: DQ_OE=1.
- STROBE: write: WE_B=0 for T_WE; read: OE_B=0 for T_ACC, RDATA captured on last STROBE cycle, LD_DAT pulses the following cycle.
- HOLD (T_HOLD): CE_B=0, strobes high, ADV_B=1, A and DQ held.
- RECOVER (T_REC): CE_B=1, DQ_OE=0; then IDLE.
- BUSY = state != IDLE. RDY = IDLE & armed & !EXECUTE.
- WE_B and OE_B never low in the same cycle; DQ_OE is never 1 while OE_B=0.
- Reset values: RDY 0 during reset (armed=0, EXECUTE unknown), BUSY 0, LD_DAT 0, RDATA 0, BPI_A 0, BPI_DQ_O 0, DQ_OE 0, CE_B/OE_B/WE_B/ADV_B 1. Reset mid-cycle aborts immediately; pins return to reset values asynchronously.

## Timing
- All outputs registered. BUSY rises the cycle after the start condition; the sequencer may drop EXECUTE the same cycle.
- Write total = T_SETUP+T_WE+T_HOLD+T_REC cycles of BUSY.
- Read: LD_DAT pulse in the first HOLD cycle; total BUSY = T_SETUP+T_ACC+T_HOLD+T_REC.
- RDY rises the cycle after RECOVER ends, provided EXECUTE is low.

## Configuration
- BPI_DQ_REG_EN defined: BPI_DQ_I passes through an input register (IOB) before capture; OE_B low extends by one cycle (T_ACC+1), LD_DAT shifts one cycle later.
- Undefined: BPI_DQ_I captured directly on the last STROBE cycle.

## Structure
- bpi_pkg: state enum encoding, default timing constants, address/data width constants (23, 16).
- Sub-module bpi_dly_cnt: 8-bit load/decrement counter with zero flag; one instance.

## Test plan
- Write, defaults, ADDR=0x012345, DATA1=0x0060, CYCLE2=0 -> WE_B low exactly 4 cycles, DQ_O=0x0060 with DQ_OE=1 over SETUP..HOLD, BUSY high 10 cycles.
- Read, model returns 0xBEEF -> OE_B low 8 cycles, LD_DAT single pulse, RDATA=0xBEEF, BUSY 14 cycles.
- Two-cycle write: EXECUTE with CYCLE2=0 then CYCLE2=1, DATA2=0x00D0 -> second cycle drives 0x00D0; no start while RDY low.
- EXECUTE held high 30 cycles -> exactly one bus cycle, RDY stays 0 until EXECUTE drops.
- RST asserted in STROBE of write -> WE_B, CE_B go 1 and DQ_OE 0 without a clock edge; BUSY 0.
- BPI_DQ_REG_EN build, read -> OE_B low 9 cycles, LD_DAT one cycle later than default.
